kronos_prog_buffer: RTL and testbench

- Test and debug program buffer that answers the Kronos core instruction-fetch bus from a small loadable RAM.
- A host (testbench or debug port) streams instr_t words in, arms the buffer, then releases the core.
- The buffer serves fetches in order, flags illegal fetch addresses, and parks the core on a self-jump once it fetches past the last loaded word.
- It sits between the host and the core's instr_addr/instr_req/instr_ack/instr_data port, in place of instruction memory.

---
 rtl/kronos_types.sv | 13 +
 rtl/kronos_prog_mem.sv | 24 ++
 rtl/kronos_prog_buffer.sv | 98 +++++++++
 tb/tb_kronos_prog_buffer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kronos_types.sv
// kronos_types: shared types and constants for the Kronos program buffer
package kronos_types;

    typedef logic [31:0] instr_t;

    typedef enum logic [2:0] {IDLE, LOAD, ARMED, RUN, DONE} prog_state_e;

    typedef enum logic [1:0] {RD_NONE, RD_SLOT, RD_NOP, RD_SPIN} rd_sel_e;

    localparam instr_t INSTR_NOP  = 32'h0000_0013;
    localparam instr_t INSTR_SPIN = 32'h0000_006F;

endpackage

// File: rtl/kronos_prog_mem.sv
// kronos_prog_mem: DEPTH x 32 program storage, one write port, registered read port
module kronos_prog_mem
    import kronos_types::*;
#(
    parameter int DEPTH = 32,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  instr_t           wdata,
    input  logic [PTR_W-1:0] raddr,
    output instr_t           rdata
);

    instr_t slots [DEPTH];

    // write on accept; read every cycle so data lines up with the following ack
    always_ff @(posedge clk) begin
        if (we) slots[waddr] <= wdata;
        rdata <= slots[raddr];
    end

endmodule

// File: rtl/kronos_prog_buffer.sv
// kronos_prog_buffer: loadable program RAM answering the Kronos instruction-fetch port
module kronos_prog_buffer
    import kronos_types::*;
#(
    parameter int          DEPTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  instr_t      load_data,
    input  logic        load_last,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output instr_t      instr_data,
    output logic        instr_ack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] fetch_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LEN_MAX = (PTR_W+1)'(DEPTH);

    prog_state_e      state;
    rd_sel_e          rd_sel;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   prog_len;
    logic [31:0]      off;
    logic [PTR_W-1:0] idx;
    logic             bad_addr;
    logic             past_end;
    logic             store;
    logic             capture;
    instr_t           mem_rdata;

    // address decode, load handshake and status outputs
    always_comb begin
        off        = instr_addr - BASE_ADDR;
        idx        = off[PTR_W+1:2];
        bad_addr   = off[1:0] != 2'b00 || off[31:PTR_W+2] != '0;
        past_end   = {1'b0, idx} >= prog_len;
        load_ready = (state == IDLE || state == LOAD) && prog_len < LEN_MAX;
        store      = load_valid && load_ready;
        capture    = (state == RUN || state == DONE) && instr_req && !instr_ack;
        busy       = state == RUN;
        done       = state == DONE;
        instr_data = rd_sel == RD_SLOT ? mem_rdata :
                     rd_sel == RD_NOP  ? INSTR_NOP :
                     rd_sel == RD_SPIN ? INSTR_SPIN : '0;
    end

    // state machine, fetch response and counters; abort behaves like reset
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state       <= IDLE;
            rd_sel      <= RD_NONE;
            wr_ptr      <= '0;
            prog_len    <= '0;
            instr_ack   <= 1'b0;
            error       <= 1'b0;
            fetch_count <= '0;
        end else begin
            instr_ack <= capture;
            rd_sel    <= !capture        ? RD_NONE :
                         state == DONE   ? RD_SPIN :
                         bad_addr        ? RD_NOP  :
                         past_end        ? RD_SPIN : RD_SLOT;
            if (store) begin
                wr_ptr   <= wr_ptr + 1'b1;
                prog_len <= prog_len + 1'b1;
                state    <= load_last ? ARMED : LOAD;
            end else if (state == ARMED && start) begin
                state <= RUN;
            end else if (capture && state == RUN && !bad_addr && past_end) begin
                state <= DONE;
            end
            if (capture && state == RUN) begin
                error       <= error | bad_addr;
                fetch_count <= fetch_count + (fetch_count != 16'hFFFF ? 16'd1 : 16'd0);
            end
        end
    end

    kronos_prog_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) mem (
        .clk   (clk),
        .we    (store),
        .waddr (wr_ptr),
        .wdata (load_data),
        .raddr (idx),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_kronos_prog_buffer.sv
// tb_kronos_prog_buffer: directed and random checks against a queue-based model
module tb_kronos_prog_buffer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] SPIN  = 32'h0000_006F;
    localparam int M_IDLE = 0, M_LOAD = 1, M_ARMED = 2, M_RUN = 3, M_DONE = 4;

    logic        clk = 0;
    logic        rst = 1;
    logic        load_valid = 0;
    logic        load_ready;
    logic [31:0] load_data = 0;
    logic        load_last = 0;
    logic        start = 0;
    logic        abort = 0;
    logic [31:0] instr_addr = 0;
    logic        instr_req = 0;
    logic [31:0] instr_data;
    logic        instr_ack;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] fetch_count;

    int checks = 0;
    int passes = 0;
    bit chk_en = 0;

    int          m_mode;
    logic [31:0] m_prog[$];
    bit          m_err;
    int          m_cnt;
    bit          m_ack;
    logic [31:0] m_data;
    bit          m_serve;
    logic [31:0] m_off;

    always #5 clk = ~clk;

    kronos_prog_buffer #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .start       (start),
        .abort       (abort),
        .instr_addr  (instr_addr),
        .instr_req   (instr_req),
        .instr_data  (instr_data),
        .instr_ack   (instr_ack),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .fetch_count (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // reference model: program kept as a queue, decoded with plain arithmetic
    always @(posedge clk) begin
        if (rst || abort) begin
            m_mode = M_IDLE;
            m_prog.delete();
            m_err  = 0;
            m_cnt  = 0;
            m_ack  = 0;
            m_data = 0;
        end else begin
            m_serve = (m_mode == M_RUN || m_mode == M_DONE) && instr_req && !m_ack;
            m_data  = 0;
            if (load_valid && m_mode <= M_LOAD && m_prog.size() < DEPTH) begin
                m_prog.push_back(load_data);
                m_mode = load_last ? M_ARMED : M_LOAD;
            end else if (m_mode == M_ARMED && start) begin
                m_mode = M_RUN;
            end else if (m_serve) begin
                if (m_mode == M_DONE) begin
                    m_data = SPIN;
                end else begin
                    m_off = instr_addr - BASE;
                    if (m_off % 4 != 0 || m_off >= 4 * DEPTH) begin
                        m_data = NOP;
                        m_err  = 1;
                    end else if (m_off / 4 < m_prog.size()) begin
                        m_data = m_prog[m_off / 4];
                    end else begin
                        m_data = SPIN;
                        m_mode = M_DONE;
                    end
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            m_ack = m_serve;
        end
    end

    // compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("load_ready", 32'(load_ready), 32'(m_mode <= M_LOAD && m_prog.size() < DEPTH));
            chk("instr_ack", 32'(instr_ack), 32'(m_ack));
            if (m_ack) chk("instr_data", instr_data, m_data);
            chk("busy", 32'(busy), 32'(m_mode == M_RUN));
            chk("done", 32'(done), 32'(m_mode == M_DONE));
            chk("error", 32'(error), 32'(m_err));
            chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        @(negedge clk);
        load_valid = 1;
        load_data  = d;
        load_last  = last;
        @(negedge clk);
        load_valid = 0;
        load_last  = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic fetch(input logic [31:0] a, output logic [31:0] d);
        bit got;
        got = 0;
        d = 'x;
        @(negedge clk);
        instr_req  = 1;
        instr_addr = a;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (instr_ack) begin
                got = 1;
                d = instr_data;
            end
        end
        instr_req = 0;
        if (!got) begin
            checks++;
            $display("FAIL fetch_timeout: no ack for address %h within 8 cycles", a);
        end
    endtask

    initial begin
        logic [31:0] d;
        int acc;
        repeat (2) @(negedge clk);
        rst = 0;
        chk_en = 1;
        @(negedge clk);
        chk("reset load_ready", 32'(load_ready), 1);
        chk("reset instr_ack", 32'(instr_ack), 0);
        chk("reset instr_data", instr_data, 0);
        chk("reset fetch_count", 32'(fetch_count), 0);

        // basic program: two words, then a fetch past the end parks the core
        load_word(32'h0050_0093, 0);
        load_word(32'h0010_8113, 1);
        pulse_start();
        fetch(32'h0, d);
        chk("prog word0", d, 32'h0050_0093);
        fetch(32'h4, d);
        chk("prog word1", d, 32'h0010_8113);
        fetch(32'h8, d);
        chk("past end spin", d, 32'h0000_006F);
        chk("done after spin", 32'(done), 1);
        chk("fetch_count 3", 32'(fetch_count), 3);
        chk("no error", 32'(error), 0);
        pulse_start();
        chk("start in DONE ignored", 32'(done), 1);
        fetch(32'h0, d);
        chk("DONE always spin", d, SPIN);
        chk("DONE count frozen", 32'(fetch_count), 3);

        // overfill: only DEPTH words accepted, no wrap, fetches stall
        do_reset();
        acc = 0;
        @(negedge clk);
        load_valid = 1;
        load_data  = $urandom;
        for (int i = 0; i < 6; i++) begin
            if (load_ready) acc++;
            @(negedge clk);
            load_data = $urandom;
        end
        load_valid = 0;
        chk("accepted words", 32'(acc), 4);
        chk("full load_ready", 32'(load_ready), 0);
        instr_req  = 1;
        instr_addr = 0;
        acc = 0;
        repeat (4) begin
            @(negedge clk);
            if (instr_ack) acc++;
        end
        instr_req = 0;
        chk("no ack in LOAD", 32'(acc), 0);
        chk("LOAD not busy", 32'(busy), 0);

        // illegal addresses give NOP and a sticky error, core keeps running
        do_reset();
        pulse_start();
        chk("start in IDLE ignored", 32'(busy), 0);
        load_word(32'h1111_1111, 1);
        pulse_start();
        fetch(32'h2, d);
        chk("misaligned nop", d, NOP);
        fetch(32'h100, d);
        chk("out of range nop", d, NOP);
        chk("error sticky", 32'(error), 1);
        chk("still busy", 32'(busy), 1);

        // held request: ack every other cycle
        do_reset();
        load_word(32'h2222_2222, 0);
        load_word(32'h3333_3333, 1);
        pulse_start();
        @(negedge clk);
        instr_req  = 1;
        instr_addr = 0;
        acc = 0;
        repeat (10) begin
            @(negedge clk);
            if (instr_ack) acc++;
        end
        instr_req = 0;
        chk("held req acks", 32'(acc), 5);
        chk("held req count", 32'(fetch_count), 5);

        // abort on the capture cycle drops the ack and clears everything
        @(negedge clk);
        instr_req = 1;
        abort = 1;
        @(negedge clk);
        instr_req = 0;
        abort = 0;
        chk("abort drops ack", 32'(instr_ack), 0);
        chk("abort load_ready", 32'(load_ready), 1);
        chk("abort prog_len", 32'(dut.prog_len), 0);
        chk("abort count", 32'(fetch_count), 0);

        // start together with abort in ARMED lands in IDLE
        load_word(32'h4444_4444, 1);
        @(negedge clk);
        start = 1;
        abort = 1;
        @(negedge clk);
        start = 0;
        abort = 0;
        chk("start+abort idle", 32'(busy), 0);
        chk("start+abort ready", 32'(load_ready), 1);

        // random traffic checked purely by the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst        = $urandom_range(0, 199) == 0;
            abort      = $urandom_range(0, 99) == 0;
            start      = $urandom_range(0, 7) == 0;
            load_valid = $urandom_range(0, 1) == 0;
            load_data  = $urandom;
            load_last  = $urandom_range(0, 3) == 0;
            instr_req  = $urandom_range(0, 3) != 0;
            case ($urandom_range(0, 5))
                0: instr_addr = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
                1: instr_addr = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
                2: instr_addr = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
                3: instr_addr = BASE + 32'(DEPTH * 4);
                4: instr_addr = BASE - 32'd4;
                default: instr_addr = $urandom;
            endcase
        end
        @(negedge clk);
        rst = 0;
        abort = 0;
        start = 0;
        load_valid = 0;
        instr_req = 0;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
